// File: rtl/wb_stage.sv
// Writeback stage: commits register writes, CP0 moves, exceptions, ERET and TLB ops,
// and raises the pipeline flush. A small FSM holds TLB instructions for the TLB latency.
package wb_stage_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] program_count;
        logic        register_file_write_enabled;
        logic [3:0]  register_file_write_strobe;
        logic [4:0]  register_file_write_address;
        logic [31:0] final_result;
        logic        move_from_cp0;
        logic        move_to_cp0;
        logic [4:0]  cp0_register;
        logic [2:0]  cp0_select;
        logic        exception_valid;
        logic [4:0]  exception_code;
        logic        exception_in_delay_slot;
        logic        is_address_fault;
        logic [31:0] badvaddr;
        logic        eret_flush;
        logic        tlb_read;
        logic        tlb_write;
        logic        tlb_probe;
    } io_to_wb_bus_t;
endpackage

module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] EXCEPTION_ENTRY  = 32'hBFC00380,
    parameter int          TLB_STALL_CYCLES = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  io_to_wb_bus_t io_to_wb_bus,
    output logic          wb_allow_in,
    output logic [3:0]    rf_write_strobe,
    output logic [4:0]    rf_write_address,
    output logic [31:0]   rf_write_data,
    output logic          wb_to_id_back_pass_valid,
    output logic [4:0]    wb_to_id_back_pass_register,
    output logic [31:0]   wb_to_id_back_pass_data,
    output logic [7:0]    cp0_address,
    output logic          cp0_write_enable,
    output logic [31:0]   cp0_write_data,
    input  logic [31:0]   cp0_read_data,
    input  logic [31:0]   cp0_epc,
    output logic          exception_commit,
    output logic [4:0]    exception_code,
    output logic [31:0]   exception_pc,
    output logic          exception_in_delay_slot,
    output logic          exception_badvaddr_valid,
    output logic [31:0]   exception_badvaddr,
    output logic          eret_commit,
    output logic          tlb_read_enable,
    output logic          tlb_write_enable,
    output logic          tlb_probe_enable,
    output logic          flush_valid,
    output logic [31:0]   flush_target,
    output logic [31:0]   debug_wb_pc,
    output logic [3:0]    debug_wb_rf_write_strobe,
    output logic [4:0]    debug_wb_rf_write_number,
    output logic [31:0]   debug_wb_rf_write_data
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] TLB_WAIT = 1'b1;
    localparam logic [1:0] LP_STALL = 2'(TLB_STALL_CYCLES);

    // The captured bus carries its own valid bit, which is the stage's wb_valid.
    io_to_wb_bus_t r_bus;
    logic [0:0]    r_state;
    logic [1:0]    r_cnt;

    logic        w_wb_valid, w_tlb_path, w_ready_go, w_commit;
    logic        w_rf_write, w_tlb_refetch;
    logic [31:0] w_result;

    assign w_wb_valid = r_bus.valid;
    // TLB ops carrying an exception skip the hold and commit as exceptions.
    assign w_tlb_path = w_wb_valid && !r_bus.exception_valid
                        && (r_bus.tlb_read || r_bus.tlb_write || r_bus.tlb_probe);
    assign w_ready_go = !w_tlb_path || (r_state == TLB_WAIT && r_cnt == LP_STALL);
    assign w_commit   = w_wb_valid && w_ready_go;

    assign w_rf_write = r_bus.register_file_write_enabled && !r_bus.exception_valid
                        && (r_bus.register_file_write_address != 5'd0);
    assign w_result   = r_bus.move_from_cp0 ? cp0_read_data : r_bus.final_result;

    assign rf_write_strobe  = (w_commit && w_rf_write) ? r_bus.register_file_write_strobe : 4'h0;
    assign rf_write_address = w_commit ? r_bus.register_file_write_address : 5'd0;
    assign rf_write_data    = w_commit ? w_result : 32'h0;

    assign wb_to_id_back_pass_valid    = w_wb_valid && w_rf_write;
    assign wb_to_id_back_pass_register = wb_to_id_back_pass_valid ? r_bus.register_file_write_address : 5'd0;
    assign wb_to_id_back_pass_data     = wb_to_id_back_pass_valid ? w_result : 32'h0;

    assign cp0_address      = {r_bus.cp0_register, r_bus.cp0_select};
    assign cp0_write_enable = w_commit && r_bus.move_to_cp0 && !r_bus.exception_valid;
    assign cp0_write_data   = cp0_write_enable ? r_bus.final_result : 32'h0;

    assign exception_commit         = w_commit && r_bus.exception_valid;
    assign exception_code           = exception_commit ? r_bus.exception_code : 5'd0;
    assign exception_pc             = exception_commit ? r_bus.program_count : 32'h0;
    assign exception_in_delay_slot  = exception_commit && r_bus.exception_in_delay_slot;
    assign exception_badvaddr_valid = exception_commit && r_bus.is_address_fault;
    assign exception_badvaddr       = exception_commit ? r_bus.badvaddr : 32'h0;

    assign eret_commit   = w_commit && r_bus.eret_flush && !r_bus.exception_valid;
    assign w_tlb_refetch = w_commit && w_tlb_path && (r_bus.tlb_write || r_bus.tlb_read);

    assign tlb_read_enable  = w_tlb_path && r_state == IDLE && r_bus.tlb_read;
    assign tlb_write_enable = w_tlb_path && r_state == IDLE && r_bus.tlb_write;
    assign tlb_probe_enable = w_tlb_path && r_state == IDLE && r_bus.tlb_probe;

    assign flush_valid  = exception_commit || eret_commit || w_tlb_refetch;
    assign flush_target = exception_commit ? EXCEPTION_ENTRY :
                          eret_commit      ? cp0_epc :
                          w_tlb_refetch    ? r_bus.program_count + 32'd4 : 32'h0;

    assign wb_allow_in = !w_wb_valid || (w_ready_go && !flush_valid);

    assign debug_wb_pc              = w_commit ? r_bus.program_count : 32'h0;
    assign debug_wb_rf_write_strobe = rf_write_strobe;
    assign debug_wb_rf_write_number = rf_write_address;
    assign debug_wb_rf_write_data   = rf_write_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bus <= '0;
        end else if (flush_valid) begin
            r_bus.valid <= 1'b0;
        end else if (wb_allow_in) begin
            if (io_to_wb_bus.valid) r_bus <= io_to_wb_bus;
            else                    r_bus.valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else if (r_state == IDLE) begin
            if (w_tlb_path) begin
                r_state <= TLB_WAIT;
                r_cnt   <= 2'd1;
            end
        end else if (w_commit) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else if (r_cnt != LP_STALL) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter EXCEPTION_ENTRY, default 32'hBFC00380: flush target for every exception.
REQ-002 Parameter TLB_STALL_CYCLES, default 1: extra hold cycles for a TLB read, write or probe (range 1..3).
REQ-003 clock  in  1: the single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1: asynchronous, active-low reset.
REQ-005 io_to_wb_bus  in  io_to_wb_bus_t: payload from the IO stage; its valid field is the IO-stage output-valid.
REQ-006 wb_allow_in  out  1: WB stage can accept a new instruction this cycle.
REQ-007 rf_write_strobe  out  4: register-file byte write enables.
REQ-008 rf_write_address  out  5: register-file write address.
REQ-009 rf_write_data  out  32: register-file write data.
REQ-010 wb_to_id_back_pass_valid  out  1: WB holds a valid register writer.
REQ-011 wb_to_id_back_pass_register  out  5: destination register for ID bypass.
REQ-012 wb_to_id_back_pass_data  out  32: bypass data.
REQ-013 cp0_address  out  8: CP0 access address, {register[4:0], select[2:0]}.
REQ-014 cp0_write_enable  out  1: MTC0 commit pulse.
REQ-015 cp0_write_data  out  32: MTC0 data.
REQ-016 cp0_read_data  in  32: MFC0 data from CP0, same cycle.
REQ-017 cp0_epc  in  32: current EPC.
REQ-018 exception_commit  out  1: exception commit pulse to CP0; carries exception_code(5), exception_pc(32), exception_in_delay_slot(1), exception_badvaddr_valid(1), exception_badvaddr(32).
REQ-019 eret_commit  out  1: ERET commit pulse.
REQ-020 tlb_read_enable, tlb_write_enable, tlb_probe_enable  out  1 each: TLB operation pulses.
REQ-021 flush_valid  out  1 and flush_target  out  32: pipeline flush request and refetch address.
REQ-022 debug_wb_pc  out  32, debug_wb_rf_write_strobe  out  4, debug_wb_rf_write_number  out  5, debug_wb_rf_write_data  out  32: trace port.

Function
REQ-023 Internal state: wb_valid, captured bus, FSM {IDLE, TLB_WAIT}, stall counter (2 bits).
REQ-024 wb_ready_go: 1 in IDLE for non-TLB instructions; 0 in the first cycle of a TLB instruction and while in TLB_WAIT until the counter reaches TLB_STALL_CYCLES.
REQ-025 wb_allow_in = !wb_valid || (wb_ready_go && !flush_valid).
REQ-026 Capture: on the rising edge, when io valid is 1 and wb_allow_in is 1, load the bus and set wb_valid = 1.
REQ-027 When wb_allow_in is 1 and io valid is 0, clear wb_valid.
REQ-028 When flush_valid is 1, clear wb_valid on the next edge and drop any incoming instruction.
REQ-029 A committing instruction is one with wb_valid && wb_ready_go; all commit outputs are gated by this.
REQ-030 Register write: rf_write_strobe = register_file_write_strobe when committing, register_file_write_enabled is 1, exception_valid is 0 and the address is not 0; otherwise 0.
REQ-031 Register write data: rf_write_data = cp0_read_data when move_from_cp0 is 1, else final_result.
REQ-032 cp0_address is driven combinationally from the captured bus at all times.
REQ-033 cp0_write_enable = commit && move_to_cp0 && !exception_valid.
REQ-034 exception_commit = commit && exception_valid; exception_badvaddr_valid = is_address_fault.
REQ-035 eret_commit = commit && eret_flush && !exception_valid.
REQ-036 flush_valid = exception_commit || eret_commit || commit of tlb_write or tlb_read.
REQ-037 flush_target priority: exception -> EXCEPTION_ENTRY; eret -> cp0_epc; TLB refetch -> program_count + 4 (32-bit wrap).
REQ-038 TLB FSM: IDLE with a valid TLB instruction, no exception -> pulse the matching tlb_*_enable for one cycle, counter = 1, go to TLB_WAIT.
REQ-039 TLB_WAIT: the counter increments each cycle; ready_go = 1 when counter == TLB_STALL_CYCLES; on commit, return to IDLE.
REQ-040 A TLB instruction with exception_valid = 1 bypasses the FSM and commits in one cycle as an exception.
REQ-041 Back-pass: valid = wb_valid && write enabled && address != 0 && !exception_valid; data follows REQ-031; asserted even while stalled.
REQ-042 The debug outputs mirror rf_write_* and program_count, and are 0 when not committing.

Reset
REQ-043 reset_n low asynchronously clears wb_valid, the FSM (to IDLE), the counter and the captured bus; all outputs read 0 and wb_allow_in reads 1.
REQ-044 Reset asserted mid-TLB_WAIT abandons the instruction with no commit pulse.

Verification
REQ-045 ALU writes r5 = 32'h1234_5678, strobe 4'hF -> one cycle later rf_write_strobe = F, address 5, data 1234_5678; back-pass valid.
REQ-046 Write to r0 -> rf_write_strobe = 0 and back-pass valid = 0.
REQ-047 Exception, code 5'h04, PC 32'h8000_0100, badvaddr 32'h0000_0003 -> exception_commit = 1, no register write, flush_target = BFC00380, and the next IO instruction is dropped.
REQ-048 ERET with cp0_epc = 32'h8000_2000 -> eret_commit = 1 and flush_target = 8000_2000.
REQ-049 TLBWI at PC 32'h8000_0040, TLB_STALL_CYCLES = 1 -> tlb_write_enable pulses once, wb_allow_in = 0 for one cycle, then flush_target = 8000_0044.
REQ-050 reset_n asserted during TLB_WAIT -> no flush and no pulse; wb_allow_in = 1 immediately.
